// File: rtl/spi_dac_writer_if.sv
// Sample handshake and status bundle between a sample producer and spi_dac_writer.
interface spi_dac_writer_if;
  logic [11:0] Data_In;
  logic [3:0]  Cfg_In;
  logic        Data_Valid;
  logic        Data_Ready;
  logic        Busy;
  logic        Done;

  modport master (
    output Data_In, Cfg_In, Data_Valid,
    input  Data_Ready, Busy, Done
  );

  modport slave (
    input  Data_In, Cfg_In, Data_Valid,
    output Data_Ready, Busy, Done
  );
endinterface

// File: rtl/spi_dac_writer.sv
// SPI master transmitter: writes {cfg[3:0], sample[11:0]} to a serial DAC as one
// 16-bit MSB-first frame. SCLK idles low, the DAC samples on SCLK rising edges,
// SDI only changes on SCLK falling edges. All outputs come straight from flops.
module spi_dac_writer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST,
  spi_dac_writer_if.slave  bus,
  output logic             DAC_CS,
  output logic             DAC_SCLK,
  output logic             DAC_SDI
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [3:0]  bit_q,   bit_d;
  logic [14:0] shreg_q, shreg_d;
  logic        cs_q,    cs_d;
  logic        sclk_q,  sclk_d;
  logic        sdi_q,   sdi_d;
  logic        ready_q, ready_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  assign DAC_CS         = cs_q;
  assign DAC_SCLK       = sclk_q;
  assign DAC_SDI        = sdi_q;
  assign bus.Data_Ready = ready_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;

  // State and output registers; reset forces an idle bus immediately.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    sdi_d   = sdi_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready comes up one edge after reset and stays up until a frame is taken.
        ready_d = 1'b1;
        if (ready_q && bus.Data_Valid) begin
          state_d = SETUP;
          phase_d = '0;
          bit_d   = '0;
          cs_d    = 1'b0;
          sdi_d   = bus.Cfg_In[3];
          shreg_d = {bus.Cfg_In[2:0], bus.Data_In};
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      SETUP: begin
        if (phase_q == DIV_LAST) begin
          state_d = SHIFT;
          phase_d = '0;
          sclk_d  = 1'b1;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      SHIFT: begin
        // Each bit is a full high+low SCLK period; the low half of bit 0
        // completes here before HOLD adds its extra CLK_DIV of CS-low time.
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q != 4'd15) begin
              sdi_d   = shreg_q[14];
              shreg_d = {shreg_q[13:0], 1'b0};
            end
          end else if (bit_q == 4'd15) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + 4'd1;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      HOLD: begin
        if (phase_q == DIV_LAST) begin
          state_d = GAP;
          phase_d = '0;
          cs_d    = 1'b1;
          sdi_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      GAP: begin
        if (phase_q == GAP_LAST) begin
          state_d = IDLE;
          phase_d = '0;
          bit_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_dac_writer.sv
// Bench for spi_dac_writer: two instances (default timing and CLK_DIV=1/GAP_CYC=1)
// checked every cycle against a frame-offset model, plus a serial-line monitor
// that reassembles each frame from SCLK rising edges.
module tb_spi_dac_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_dac_writer_if bus0();
  spi_dac_writer_if bus1();

  logic o_cs[2], o_sclk[2], o_sdi[2];
  logic r_ready[2], r_busy[2], r_done[2], v_in[2];
  logic [15:0] w_in[2];

  assign r_ready[0] = bus0.Data_Ready;
  assign r_busy[0]  = bus0.Busy;
  assign r_done[0]  = bus0.Done;
  assign v_in[0]    = bus0.Data_Valid;
  assign w_in[0]    = {bus0.Cfg_In, bus0.Data_In};
  assign r_ready[1] = bus1.Data_Ready;
  assign r_busy[1]  = bus1.Busy;
  assign r_done[1]  = bus1.Done;
  assign v_in[1]    = bus1.Data_Valid;
  assign w_in[1]    = {bus1.Cfg_In, bus1.Data_In};

  spi_dac_writer #(.CLK_DIV(4), .GAP_CYC(2)) dut0 (
    .Sys_CLK(clk), .Sys_RST(rst_n), .bus(bus0),
    .DAC_CS(o_cs[0]), .DAC_SCLK(o_sclk[0]), .DAC_SDI(o_sdi[0])
  );

  spi_dac_writer #(.CLK_DIV(1), .GAP_CYC(1)) dut1 (
    .Sys_CLK(clk), .Sys_RST(rst_n), .bus(bus1),
    .DAC_CS(o_cs[1]), .DAC_SCLK(o_sclk[1]), .DAC_SDI(o_sdi[1])
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: outputs are a pure function of cycles elapsed since the accepting edge.
  int          D[2] = '{4, 1};
  int          G[2] = '{2, 1};
  int          m_cyc[2], m_acc[2];
  bit          m_active[2], m_ready[2];
  logic [15:0] m_word[2];

  // Monitor state.
  bit          prev_cs[2], prev_sclk[2], in_frame[2];
  int          mon_len[2], mon_rises[2], mon_hi[2], mon_frames[2];
  logic [15:0] mon_cap[2];
  logic [15:0] mon_last_word[2];
  int          mon_last_len[2], mon_last_rises[2], mon_last_hi[2];

  // Per-cycle model update, output comparison and frame reassembly.
  always @(negedge clk) begin
    int t, k, dd, gg;
    bit e_cs, e_sclk, e_sdi, e_done, e_busy;
    for (int u = 0; u < 2; u++) begin
      dd = D[u];
      gg = G[u];
      if (!rst_n) begin
        m_cyc[u] = 0; m_acc[u] = 0; m_active[u] = 0; m_ready[u] = 0;
        prev_cs[u] = 1; prev_sclk[u] = 0; in_frame[u] = 0; mon_hi[u] = 0;
        chk($sformatf("u%0d rst cs", u), int'(o_cs[u]), 1);
        chk($sformatf("u%0d rst sclk", u), int'(o_sclk[u]), 0);
        chk($sformatf("u%0d rst sdi", u), int'(o_sdi[u]), 0);
        chk($sformatf("u%0d rst ready", u), int'(r_ready[u]), 0);
        chk($sformatf("u%0d rst busy", u), int'(r_busy[u]), 0);
        chk($sformatf("u%0d rst done", u), int'(r_done[u]), 0);
      end else begin
        m_cyc[u]++;
        if (m_ready[u] && v_in[u]) begin
          m_active[u] = 1;
          m_acc[u] = m_cyc[u];
          m_word[u] = w_in[u];
        end
        t = m_cyc[u] - m_acc[u];
        if (m_active[u] && t >= 34*dd + gg) m_active[u] = 0;
        if (m_active[u]) begin
          k = t / (2*dd);
          if (k > 15) k = 15;
          e_cs   = !(t < 34*dd);
          e_sclk = (t >= dd) && (t < 33*dd) && ((((t - dd) / dd) % 2) == 0);
          e_sdi  = (t < 34*dd) ? m_word[u][15 - k] : 1'b0;
          e_done = (t == 34*dd);
          e_busy = 1'b1;
        end else begin
          e_cs = 1; e_sclk = 0; e_sdi = 0; e_done = 0; e_busy = 0;
        end
        m_ready[u] = !m_active[u];
        chk($sformatf("u%0d cyc%0d cs", u, m_cyc[u]), int'(o_cs[u]), int'(e_cs));
        chk($sformatf("u%0d cyc%0d sclk", u, m_cyc[u]), int'(o_sclk[u]), int'(e_sclk));
        chk($sformatf("u%0d cyc%0d sdi", u, m_cyc[u]), int'(o_sdi[u]), int'(e_sdi));
        chk($sformatf("u%0d cyc%0d done", u, m_cyc[u]), int'(r_done[u]), int'(e_done));
        chk($sformatf("u%0d cyc%0d busy", u, m_cyc[u]), int'(r_busy[u]), int'(e_busy));
        chk($sformatf("u%0d cyc%0d ready", u, m_cyc[u]), int'(r_ready[u]), int'(m_ready[u]));

        if (prev_cs[u] && !o_cs[u]) begin
          in_frame[u] = 1; mon_len[u] = 0; mon_rises[u] = 0; mon_cap[u] = '0;
          mon_last_hi[u] = mon_hi[u];
        end
        if (!o_cs[u]) begin
          mon_len[u]++;
          if (!prev_sclk[u] && o_sclk[u]) begin
            mon_cap[u] = {mon_cap[u][14:0], o_sdi[u]};
            mon_rises[u]++;
          end
        end else if (!prev_cs[u]) begin
          mon_hi[u] = 1;
          if (in_frame[u]) begin
            chk($sformatf("u%0d frame word", u), int'(mon_cap[u]), int'(m_word[u]));
            chk($sformatf("u%0d frame rises", u), mon_rises[u], 16);
            chk($sformatf("u%0d frame cs_low", u), mon_len[u], 34*dd);
            mon_last_word[u] = mon_cap[u];
            mon_last_len[u] = mon_len[u];
            mon_last_rises[u] = mon_rises[u];
            mon_frames[u]++;
            in_frame[u] = 0;
          end
        end else begin
          mon_hi[u]++;
        end
        prev_cs[u] = o_cs[u];
        prev_sclk[u] = o_sclk[u];
      end
    end
  end

  task automatic drive(input int u, input logic v, input logic [15:0] w);
    if (u == 0) begin
      bus0.Data_Valid = v; bus0.Cfg_In = w[15:12]; bus0.Data_In = w[11:0];
    end else begin
      bus1.Data_Valid = v; bus1.Cfg_In = w[15:12]; bus1.Data_In = w[11:0];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_model_ready(input int u);
    int n = 0;
    while (!m_ready[u] && n < 500) begin
      tick();
      n++;
    end
    if (!m_ready[u]) chk($sformatf("u%0d ready timeout", u), 0, 1);
  endtask

  task automatic send(input int u, input logic [15:0] w);
    wait_model_ready(u);
    drive(u, 1'b1, w);
    tick();
    drive(u, 1'b0, 16'($urandom));
  endtask

  task automatic wait_frames(input int u, input int n_target);
    int n = 0;
    while (mon_frames[u] < n_target && n < 2000) begin
      tick();
      n++;
    end
    chk($sformatf("u%0d frame count", u), mon_frames[u], n_target);
  endtask

  initial begin
    int n;
    mon_frames[0] = 0;
    mon_frames[1] = 0;
    drive(0, 1'b0, 16'h0000);
    drive(1, 1'b0, 16'h0000);
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst cs literal", int'(o_cs[0]), 1);
    chk("rst ready literal", int'(r_ready[0]), 0);
    rst_n = 1'b1;
    tick();
    chk("ready after rst", int'(r_ready[0]), 1);
    chk("ready after rst u1", int'(r_ready[1]), 1);

    // First frame on both instances; glitch Data_Valid on unit 0 mid-frame.
    fork
      send(0, 16'h3A5C);
      send(1, 16'hF800);
    join
    repeat (40) tick();
    drive(0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ready low in frame", int'(r_ready[0]), 0);
    end
    drive(0, 1'b0, 16'h0000);
    wait_frames(0, 1);
    chk("f1 word", int'(mon_last_word[0]), 16'h3A5C);
    chk("f1 rises", mon_last_rises[0], 16);
    chk("f1 cs low", mon_last_len[0], 136);
    chk("div1 word", int'(mon_last_word[1]), 16'hF800);
    chk("div1 cs low", mon_last_len[1], 34);

    // All-zero frame.
    send(0, 16'h0000);
    wait_frames(0, 2);
    chk("zero word", int'(mon_last_word[0]), 0);
    chk("zero cs low", mon_last_len[0], 136);

    // Data_Valid held high across two frames.
    wait_model_ready(0);
    drive(0, 1'b1, 16'h9ABC);
    n = 0;
    do begin tick(); n++; end while (r_ready[0] && n < 300);
    drive(0, 1'b1, 16'h5123);
    n = 0;
    do begin tick(); n++; end while (!r_ready[0] && n < 300);
    chk("accept to ready", n, 138);
    tick();
    drive(0, 1'b0, 16'h0000);
    wait_frames(0, 4);
    chk("b2b word", int'(mon_last_word[0]), 16'h5123);
    chk("b2b cs gap >= 2", int'(mon_last_hi[0] >= 2), 1);

    // Asynchronous reset while bit 7 is on the wire with SCLK high.
    send(0, 16'h1734);
    repeat (61) tick();
    chk("pre-rst sclk", int'(o_sclk[0]), 1);
    chk("pre-rst sdi", int'(o_sdi[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async cs", int'(o_cs[0]), 1);
    chk("async sclk", int'(o_sclk[0]), 0);
    chk("async sdi", int'(o_sdi[0]), 0);
    chk("async ready", int'(r_ready[0]), 0);
    chk("async done", int'(r_done[0]), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("no frame after rst", mon_frames[0], 4);
    send(0, 16'h0001);
    wait_frames(0, 5);
    chk("post-rst word", int'(mon_last_word[0]), 16'h0001);

    // Randomised traffic on both instances.
    fork
      for (int i = 0; i < 1500; i++) begin
        drive(0, ($urandom_range(0, 3) == 0), 16'($urandom));
        tick();
      end
      for (int j = 0; j < 1500; j++) begin
        drive(1, ($urandom_range(0, 2) == 0), 16'($urandom));
        tick();
      end
    join
    drive(0, 1'b0, 16'h0000);
    drive(1, 1'b0, 16'h0000);
    repeat (200) tick();
    chk("random frames seen", int'(mon_frames[0] > 6 && mon_frames[1] > 20), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
